// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS load/store unit.
package mips_mem_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;

    // Access size as carried on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    // Load/store controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/mips_lsu_if.sv
// Request/response handshake plus word-organised memory port of the LSU.
// master = datapath and memory side, slave = the LSU itself.
interface mips_lsu_if #(
    parameter int AW     = 32,
    parameter int MEM_AW = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [AW-1:0]     req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_wrt;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_wrt, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_wrt, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mips_lsu_align.sv
// Combinational lane extraction/extension for loads and lane merge for
// stores. Lanes are little-endian; halves align down to lane[1].
module mips_lsu_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [BYTE_W-1:0] byte_sel;
    logic [15:0]       half_sel;
    logic [4:0]        byte_lsb;

    // Select the addressed lane and build both the load and merge results.
    always_comb begin
        byte_lsb   = {lane, 3'b000};
        byte_sel   = word[byte_lsb +: BYTE_W];
        half_sel   = lane[1] ? word[31:16] : word[15:0];
        load_val   = '0;
        store_word = word;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                store_word[byte_lsb +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_val = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                if (lane[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            SZ_WORD: begin
                load_val   = word;
                store_word = wdata;
            end
            default: begin
                load_val   = '0;
                store_word = word;
            end
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one request at a time, sub-word stores done as
// read-modify-write against a combinational-read word memory.
// Optional macro MIPS_LSU_MISALIGN_CHK_EN rejects misaligned half/word
// accesses; without it the low address bits are simply ignored.
module mips_lsu
    import mips_mem_pkg::*;
#(
    parameter int AW     = 32,
    parameter int MEM_AW = 32
) (
    input  logic       clk,
    input  logic       reset,
    mips_lsu_if.slave  bus
);

    lsu_state_e    state_q, state_d;
    logic          wr_q, wr_d;
    size_e         size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          req_ready;
    logic          mem_wrt;
    logic [31:0]   mem_wdata;
    logic          misaligned;
    size_e         req_size_e;
    logic [31:0]   align_word;
    logic [31:0]   load_val;
    logic [31:0]   store_word;

    assign req_size_e = size_e'(bus.req_size);

`ifdef MIPS_LSU_MISALIGN_CHK_EN
    assign misaligned = ((req_size_e == SZ_HALF) && bus.req_addr[0]) ||
                        ((req_size_e == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // The merge path works on the word captured during ACCESS; loads and
    // word stores use the live memory read.
    assign align_word = (state_q == MERGE) ? merge_q : bus.mem_rdata;

    mips_lsu_align u_align (
        .word        (align_word),
        .lane        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_val    (load_val),
        .store_word  (store_word)
    );

    // Next-state, latching and memory-port control.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        mem_wrt   = 1'b0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    size_d  = req_size_e;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    if ((req_size_e == SZ_BAD) || misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!wr_q) begin
                    rdata_d = load_val;
                    state_d = RESP;
                end else if (size_q == SZ_WORD) begin
                    mem_wrt   = 1'b1;
                    mem_wdata = store_word;
                    state_d   = RESP;
                end else begin
                    merge_d = bus.mem_rdata;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                mem_wrt   = 1'b1;
                mem_wdata = store_word;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request registers; reset aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_wrt   = mem_wrt;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_addr  = MEM_AW'(addr_q[AW-1:2]);

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: directed vector table, reset-abort
// sequence and randomized traffic against a behavioural memory model.
module tb_mips_lsu;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_lsu_if #(.AW(32), .MEM_AW(32)) bus ();

    mips_lsu #(.AW(32), .MEM_AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory the DUT talks to.
    logic [31:0] mem [0:63];
    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
    always @(posedge clk) begin
        if (bus.mem_wrt) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end

    // Reference memory image maintained from the architectural rules.
    logic [31:0] ref_mem [0:63];

    int checks;
    int failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                             input bit uns, input logic [31:0] addr);
        longint v;
        case (size)
            2'd0: begin
                v = longint'((w >> (8 * int'(addr[1:0]))) & 32'hFF);
                if (!uns && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = longint'((w >> (16 * int'(addr[1]))) & 32'hFFFF);
                if (!uns && v >= 32768) v = v - 65536;
            end
            2'd2:    v = longint'(w);
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] d);
        int sh;
        logic [31:0] m;
        case (size)
            2'd0: begin
                sh = 8 * int'(addr[1:0]);
                m  = 32'hFF << sh;
                return (w & ~m) | ((d & 32'hFF) << sh);
            end
            2'd1: begin
                sh = 16 * int'(addr[1]);
                m  = 32'hFFFF << sh;
                return (w & ~m) | ((d & 32'hFFFF) << sh);
            end
            2'd2:    return d;
            default: return w;
        endcase
    endfunction

    function automatic bit ref_reject(input logic [1:0] size, input logic [31:0] addr);
`ifdef MIPS_LSU_MISALIGN_CHK_EN
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`else
        return (size == 2'd3);
`endif
    endfunction

    // One complete transaction; starts and ends #1 after a rising edge.
    task automatic do_op(input bit wr, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int wrts, output logic [31:0] waddr);
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_wr       = wr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        @(posedge clk); #1;
        bus.req_valid    = 1'b0;
        bus.req_wr       = ~wr;
        bus.req_size     = 2'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        lat   = 0;
        wrts  = 0;
        waddr = '0;
        rdata = '0;
        err   = 1'b0;
        while (lat < 10) begin
            lat++;
            if (bus.rsp_valid) break;
            check("busy_req_ready", 32'(bus.req_ready), 32'd0);
            if (bus.mem_wrt) begin
                wrts++;
                waddr = bus.mem_addr;
            end else begin
                check("wdata_zero_when_idle", bus.mem_wdata, 32'd0);
            end
            @(posedge clk); #1;
        end
        check("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
        check("resp_mem_wrt", 32'(bus.mem_wrt), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            check("hold_mem_wrt", 32'(bus.mem_wrt), 32'd0);
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("idle_after_rsp_ready", 32'(bus.req_ready), 32'd1);
        check("idle_after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wrts;
        int          chk_word;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[$];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat, wrts;
        logic [31:0] waddr;
        checks   = 0;
        failures = 0;

        // Directed vectors: word 5 = 0x8899AABB before the first access.
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h15, 32'h0,        0, 32'hFFFFFFAA, 1'b0, 2, 0, 5, 32'h8899AABB});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h16, 32'h0,        0, 32'h00008899, 1'b0, 2, 0, 5, 32'h8899AABB});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h14, 32'h0,        1, 32'h8899AABB, 1'b0, 2, 0, 5, 32'h8899AABB});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h17, 32'h5C,       0, 32'h0,        1'b0, 3, 1, 5, 32'h5C99AABB});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 3, 32'h0,        1'b0, 2, 1, 8, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h14, 32'h0,        0, 32'h0,        1'b1, 1, 0, 5, 32'h5C99AABB});
        vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h20, 32'h11111111, 2, 32'h0,        1'b1, 1, 0, 8, 32'hDEADBEEF});
`ifdef MIPS_LSU_MISALIGN_CHK_EN
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h21, 32'h1234,     0, 32'h0,        1'b1, 1, 0, 8, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h23, 32'h0,        0, 32'h0,        1'b1, 1, 0, 8, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h22, 32'h0,        0, 32'h0,        1'b1, 1, 0, 8, 32'hDEADBEEF});
`else
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h21, 32'h1234,     0, 32'h0,        1'b0, 3, 1, 8, 32'hDEAD1234});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h23, 32'h0,        0, 32'hFFFFDEAD, 1'b0, 2, 0, 8, 32'hDEAD1234});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h22, 32'h0,        0, 32'hDEAD1234, 1'b0, 2, 0, 8, 32'hDEAD1234});
`endif
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        0, 32'h000000DE, 1'b0, 2, 0, 8, vecs[vecs.size()-1].exp_word});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h14, 32'h0,        0, 32'hFFFFFFBB, 1'b0, 2, 0, 5, 32'h5C99AABB});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFFCAFE, 0, 32'h0,        1'b0, 3, 1, 5, 32'hCAFEAABB});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h16, 32'h0,        0, 32'hFFFFCAFE, 1'b0, 2, 0, 5, 32'hCAFEAABB});

        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5]     = 32'h8899AABB;
        ref_mem[5] = 32'h8899AABB;

        bus.req_valid    = 1'b0;
        bus.req_wr       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b0;
        reset            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset_mem_wrt", 32'(bus.mem_wrt), 32'd0);
        check("reset_mem_addr", bus.mem_addr, 32'd0);
        check("reset_mem_wdata", bus.mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        foreach (vecs[i]) begin
            do_op(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  vecs[i].hold, rdata, err, lat, wrts, waddr);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_writes", i), 32'(wrts), 32'(vecs[i].exp_wrts));
            if (vecs[i].exp_wrts != 0)
                check($sformatf("vec%0d_waddr", i), waddr, 32'(vecs[i].chk_word));
            check($sformatf("vec%0d_mem", i), mem[vecs[i].chk_word], vecs[i].exp_word);
            if (vecs[i].wr && !vecs[i].exp_err)
                ref_mem[vecs[i].addr[7:2]] = ref_store(ref_mem[vecs[i].addr[7:2]], vecs[i].size,
                                                       vecs[i].addr, vecs[i].wdata);
        end

        // Reset asserted while a byte store sits in MERGE.
        bus.req_wr    = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'h14;
        bus.req_wdata = 32'hA5;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("merge_mem_wrt", 32'(bus.mem_wrt), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_mem_wrt", 32'(bus.mem_wrt), 32'd0);
        check("abort_mem_wdata", bus.mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_mem_addr", bus.mem_addr, 32'd0);
        check("abort_mem_unchanged", mem[5], ref_mem[5]);
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            bit          r_wr, r_uns, rej;
            logic [1:0]  r_size;
            logic [31:0] r_addr, r_wdata, e_rdata;
            int          e_lat, e_wrts, w;
            r_wr    = 1'($urandom);
            r_uns   = 1'($urandom);
            r_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_addr  = 32'($urandom_range(0, 255));
            r_wdata = $urandom;
            w       = int'(r_addr[7:2]);
            rej     = ref_reject(r_size, r_addr);
            e_rdata = (r_wr || rej) ? 32'h0 : ref_load(ref_mem[w], r_size, r_uns, r_addr);
            e_lat   = rej ? 1 : ((r_wr && r_size != 2'd2) ? 3 : 2);
            e_wrts  = (r_wr && !rej) ? 1 : 0;
            if (r_wr && !rej) ref_mem[w] = ref_store(ref_mem[w], r_size, r_addr, r_wdata);
            do_op(r_wr, r_size, r_uns, r_addr, r_wdata, $urandom_range(0, 2),
                  rdata, err, lat, wrts, waddr);
            check("rnd_rdata", rdata, e_rdata);
            check("rnd_err", 32'(err), 32'(rej));
            check("rnd_latency", 32'(lat), 32'(e_lat));
            check("rnd_writes", 32'(wrts), 32'(e_wrts));
            if (e_wrts != 0) check("rnd_waddr", waddr, 32'(w));
            check("rnd_mem_word", mem[w], ref_mem[w]);
        end

        for (int i = 0; i < 64; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Load/store initiator between the MIPS datapath and the word-organised data memory.
- Accepts one byte, halfword or word load/store request at a time over a valid/ready handshake.
- Drives the memory port: combinational read, write on the rising clock edge, word-indexed address.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.

Parameters:
- AW, 32, request byte-address width.
- MEM_AW, 32, memory word-address width; mem_addr = req_addr[AW-1:2], zero-extended.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected, no memory write performed
- mem_wrt  out  1  memory write enable
- mem_addr  out  MEM_AW  memory word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - All latched request fields = 0, so mem_addr = 0.
  - mem_wrt = 0, mem_wdata = 0.
- Reset mid-operation aborts immediately. mem_wrt drops asynchronously, so no partial or merged write occurs.
- Byte lanes are little-endian: lane k = bits [8k+7:8k]; lane = addr[1:0]; half lane = addr[1].
- FSM states: IDLE, ACCESS, MERGE, RESP.
  - IDLE: req_ready = 1.
    - On req_valid, latch wr, size, unsigned, addr and wdata.
    - size 3 (or misaligned, see Optional Feature): go to RESP with rsp_err = 1 and no memory access.
    - Otherwise go to ACCESS.
  - ACCESS: mem_addr = latched word index.
    - Load: extract the lane from mem_rdata and extend it into rsp_rdata; go to RESP.
    - Word store: mem_wrt = 1, mem_wdata = wdata; go to RESP.
    - Sub-word store: capture mem_rdata into a merge register, no write; go to MERGE.
  - MERGE: mem_wrt = 1. mem_wdata = captured word with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
  - RESP: rsp_valid = 1 with rsp_rdata and rsp_err held stable until rsp_ready. On rsp_ready go to IDLE.
- req_ready = 0 in every state other than IDLE. No new request is accepted in the same cycle as the response handshake.
- Latency, with the request accepted at edge N:
  - Load or word store: rsp_valid from cycle N+2.
  - Sub-word store: rsp_valid from cycle N+3.
  - Error: rsp_valid from cycle N+1.
- mem_wrt:
  - High for exactly one cycle per store.
  - Never high in IDLE or RESP.
  - mem_wdata = 0 whenever mem_wrt = 0.
- mem_addr holds the last latched index between requests.
- Extension:
  - Signed byte: replicate bit 7.
  - Signed half: replicate bit 15.
  - Word: req_unsigned is ignored.
- rsp_ready held high in RESP gives back-to-back operation: IDLE is revisited for one cycle per request.

Optional Feature:
- Macro: MIPS_LSU_MISALIGN_CHK_EN.
- Defined: a half with addr[0] = 1, or a word with addr[1:0] != 0, is rejected. It goes straight to RESP with rsp_err = 1, rsp_rdata = 0 and no memory access.
- Undefined: the unused low address bits are ignored. A half aligns down to addr[1] and a word uses addr[AW-1:2]. rsp_err is raised only for size 3.

Decomposition:
- Package mips_mem_pkg:
  - size_e {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD}
  - lsu_state_e {IDLE, ACCESS, MERGE, RESP}
  - constants BYTE_W = 8, WORD_BYTES = 4
- One combinational sub-module, mips_lsu_align:
  - Inputs: word, lane, size, unsigned, wdata.
  - Outputs: extended load value and merged store word.
  - Shared by the ACCESS and MERGE paths.

Test Plan:
- Memory word 5 = 0x8899AABB. Load byte signed at addr 0x15 (lane 1) -> rsp_rdata = 0xFFFFFFAA, rsp_valid at N+2, mem_wrt never asserted.
- Same word, load half unsigned at addr 0x16 -> rsp_rdata = 0x00008899. Load word at 0x14 -> 0x8899AABB.
- Store byte 0x5C at addr 0x17 -> one read cycle, then one mem_wrt cycle with mem_addr = 5 and mem_wdata = 0x5C99AABB. rsp_valid at N+3, rsp_rdata = 0.
- Store word 0xDEADBEEF at 0x20 -> single mem_wrt pulse, mem_addr = 8. Hold rsp_ready = 0 for 3 cycles -> rsp_valid stays high and req_ready stays 0 throughout.
- req_size = 3, or with the macro defined a half store at 0x21 -> rsp_err = 1 at N+1, memory unchanged. Without the macro the half store writes lanes 0–1 of word 8.
- Assert reset during MERGE of a byte store -> mem_wrt = 0 immediately, memory unchanged, req_ready = 1 after release.
